// File: rtl/echo_delay_ctrl.sv
// Echo delay controller: circular buffer in an external DPRAM, one sample in flight; accept -> out_valid in 2 cycles.
// Backpressure: in_ready only in IDLE, and the output is held until out_ready, so upstream stalls for the whole transaction.
module echo_delay_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    input  logic [ADDR_WIDTH-1:0] delay_cfg,
    input  logic                  cfg_load,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] ram_a_addr,
    output logic [DATA_WIDTH-1:0] ram_a_wr_data,
    output logic                  ram_a_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_b_addr,
    output logic                  ram_b_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_b_rd_data,
    output logic                  primed
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, OUT} state_t;
    typedef enum logic [1:0] {TAG_ZERO, TAG_RAM, TAG_BYPASS} tag_t;

    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] FILL_MAX = '1;

    state_t                  state_q, state_d;
    tag_t                    tag_q, tag_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   fill_q, fill_d;
    logic [ADDR_WIDTH-1:0]   delay_q, delay_d;
    logic [ADDR_WIDTH-1:0]   pend_delay_q, pend_delay_d;
    logic                    pend_q, pend_d;
    logic                    flush_q, flush_d;
    logic [DATA_WIDTH-1:0]   bypass_q, bypass_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    accept;
    logic                    qual_idle;

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        delay_d      = delay_q;
        pend_delay_d = pend_delay_q;
        pend_d       = pend_q;
        flush_d      = flush_q;
        bypass_d     = bypass_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;

        accept    = (state_q == IDLE) && in_valid;
        qual_idle = (state_q == IDLE) && !in_valid;

        ram_a_wr_en   = accept;
        ram_a_addr    = wr_ptr_q;
        ram_a_wr_data = in_data;
        // Zero delay is served from the bypass register; steer port B away from the write slot.
        ram_b_addr    = (accept && (delay_q == '0)) ? wr_ptr_q + ONE : wr_ptr_q - delay_q;
        ram_b_wr_en   = 1'b0;
        primed        = (delay_q == '0) || (fill_q >= delay_q);

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + ONE;
                    if (fill_q != FILL_MAX) fill_d = fill_q + ONE;
                    bypass_d = in_data;
                    if (delay_q == '0)          tag_d = TAG_BYPASS;
                    else if (fill_q >= delay_q) tag_d = TAG_RAM;
                    else                        tag_d = TAG_ZERO;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                unique case (tag_q)
                    TAG_RAM:    out_data_d = ram_b_rd_data;
                    TAG_BYPASS: out_data_d = bypass_q;
                    default:    out_data_d = '0;
                endcase
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Config and flush only land between transactions so an in-flight sample keeps its context.
        if (qual_idle) begin
            if (cfg_load)    delay_d = delay_cfg;
            else if (pend_q) delay_d = pend_delay_q;
            pend_d = 1'b0;
            if (flush || flush_q) begin
                wr_ptr_d = '0;
                fill_d   = '0;
            end
            flush_d = 1'b0;
        end else begin
            if (cfg_load) begin
                pend_d       = 1'b1;
                pend_delay_d = delay_cfg;
            end
            if (flush) flush_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tag_q        <= TAG_ZERO;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            delay_q      <= '0;
            pend_delay_q <= '0;
            pend_q       <= 1'b0;
            flush_q      <= 1'b0;
            bypass_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            delay_q      <= delay_d;
            pend_delay_q <= pend_delay_d;
            pend_q       <= pend_d;
            flush_q      <= flush_d;
            bypass_q     <= bypass_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Bench for echo_delay_ctrl: sample-history model checked every cycle, plus directed literal sequences.
module tb_echo_delay_ctrl;
    localparam int AW = 10;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b1;
    logic [AW-1:0] delay_cfg = '0;
    logic          cfg_load = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] ram_a_addr;
    logic [DW-1:0] ram_a_wr_data;
    logic          ram_a_wr_en;
    logic [AW-1:0] ram_b_addr;
    logic          ram_b_wr_en;
    logic [DW-1:0] ram_b_rd_data = '0;
    logic          primed;

    always #5 clk = ~clk;

    echo_delay_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .delay_cfg(delay_cfg), .cfg_load(cfg_load), .flush(flush),
        .ram_a_addr(ram_a_addr), .ram_a_wr_data(ram_a_wr_data), .ram_a_wr_en(ram_a_wr_en),
        .ram_b_addr(ram_b_addr), .ram_b_wr_en(ram_b_wr_en), .ram_b_rd_data(ram_b_rd_data),
        .primed(primed)
    );

    // Dual-port RAM, registered read, no output register
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_a_wr_en) mem[ram_a_addr] <= ram_a_wr_data;
        ram_b_rd_data <= mem[ram_b_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: history of samples since the last flush, phase of the single transaction
    int            ph = 0;
    int            hist[$];
    int            m_delay = 0, m_pend = 0, m_pval = 0, m_fpend = 0;
    int            exp_out = 0;
    logic [DW-1:0] got_q[$];

    always @(negedge clk) begin
        int n;
        int wrp;
        bit acc;
        bit qual;
        if (!rst_n) begin
            ph = 0; hist.delete(); m_delay = 0; m_pend = 0; m_pval = 0; m_fpend = 0;
        end else begin
            n    = hist.size();
            wrp  = n % 1024;
            acc  = (ph == 0) && in_valid;
            qual = (ph == 0) && !in_valid;
            chk("in_ready", in_ready, ph == 0);
            chk("out_valid", out_valid, ph == 2);
            if (ph == 2) chk("out_data", out_data, exp_out);
            chk("primed", primed, (m_delay == 0) || (n >= m_delay));
            chk("ram_a_wr_en", ram_a_wr_en, acc);
            chk("ram_b_wr_en", ram_b_wr_en, 0);
            if (acc) begin
                chk("ram_a_addr", ram_a_addr, wrp);
                chk("ram_a_wr_data", ram_a_wr_data, in_data);
                if (m_delay != 0) chk("ram_b_addr", ram_b_addr, (wrp - m_delay + 1024) % 1024);
                else              chk("ram_b_addr_collide", ram_b_addr != ram_a_addr, 1);
            end
            if (ph == 2 && out_ready) got_q.push_back(out_data);

            case (ph)
                0: if (acc) begin
                    if (m_delay == 0)      exp_out = in_data;
                    else if (n >= m_delay) exp_out = hist[n - m_delay];
                    else                   exp_out = 0;
                    hist.push_back(int'(in_data));
                    ph = 1;
                end
                1: ph = 2;
                default: if (out_ready) ph = 0;
            endcase
            if (qual) begin
                if (cfg_load)    m_delay = delay_cfg;
                else if (m_pend) m_delay = m_pval;
                m_pend = 0;
                if (flush || m_fpend != 0) hist.delete();
                m_fpend = 0;
            end else begin
                if (cfg_load) begin m_pend = 1; m_pval = delay_cfg; end
                if (flush) m_fpend = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, output int addr);
        int t;
        t = 0;
        in_valid = 1'b0;
        while (!in_ready && t < 100) begin tick(); t++; end
        if (t >= 100) chk("send_timeout", in_ready, 1);
        tick();
        in_valid = 1'b1;
        in_data  = DW'(v);
        addr     = int'(ram_a_addr);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (!(in_ready && !out_valid) && t < 100) begin tick(); t++; end
        if (t >= 100) chk("drain_timeout", in_ready, 1);
    endtask

    task automatic pulse(input bit ld, input int d, input bit fl);
        cfg_load  = ld;
        delay_cfg = AW'(d);
        flush     = fl;
        tick();
        cfg_load = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic expect_seq(input string name, input int e[$]);
        chk({name, "_len"}, got_q.size(), e.size());
        for (int i = 0; i < e.size() && i < got_q.size(); i++) chk(name, got_q[i], e[i]);
    endtask

    initial begin
        int a;
        int bad;
        int e[$];
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_primed", primed, 1);
        chk("rst_a_addr", ram_a_addr, 0);
        chk("rst_b_addr", ram_b_addr, 0);
        chk("rst_a_wr_en", ram_a_wr_en, 0);
        rst_n = 1'b1;
        tick();

        // delay 0 bypass
        send(1, a); send(2, a); drain();
        e = '{1, 2}; expect_seq("bypass", e);

        // delay 3 with simultaneous flush
        got_q.delete();
        pulse(1, 3, 1);
        send(1, a); send(2, a);
        chk("primed_after_2", primed, 0);
        send(3, a);
        chk("primed_after_3", primed, 1);
        for (int k = 4; k <= 8; k++) send(k, a);
        drain();
        e = '{0, 0, 0, 1, 2, 3, 4, 5}; expect_seq("delay3", e);

        // output stall with in_valid held high
        got_q.delete();
        out_ready = 1'b0;
        send(9, a);
        in_valid = 1'b1; in_data = '1;
        repeat (5) tick();
        chk("stall_data", out_data, 6);
        chk("stall_in_ready", in_ready, 0);
        in_valid = 1'b0;
        drain();
        e = '{6}; expect_seq("stall", e);

        // config during RD_WAIT, flush held during RD_WAIT
        got_q.delete();
        send(10, a);
        pulse(1, 4, 0);
        send(11, a);
        pulse(0, 0, 1);
        drain();
        for (int k = 20; k <= 24; k++) send(k, a);
        drain();
        e = '{7, 7, 0, 0, 0, 0, 20}; expect_seq("cfg_flush", e);

        // maximum delay with pointer wrap
        got_q.delete();
        pulse(1, 1023, 1);
        for (int k = 0; k < 1100; k++) begin
            send(k, a);
            if (k == 1023) chk("wrap_addr_1023", a, 1023);
            if (k == 1024) chk("wrap_addr_1024", a, 0);
        end
        drain();
        chk("ramp_len", got_q.size(), 1100);
        bad = 0;
        for (int k = 0; k < got_q.size(); k++)
            if (got_q[k] !== DW'((k >= 1023) ? k - 1023 : 0)) bad++;
        chk("ramp_bad", bad, 0);

        // reset during OUT
        out_ready = 1'b0;
        send(99, a);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_primed", primed, 1);
        chk("mid_rst_b_addr", ram_b_addr, 0);
        tick(); tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        got_q.delete();
        pulse(1, 2, 0);
        send(5, a); send(6, a); send(7, a);
        drain();
        e = '{0, 0, 5}; expect_seq("post_reset", e);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_load  = ($urandom_range(0, 39) == 0);
            delay_cfg = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 1023)) : AW'($urandom_range(0, 12));
            flush     = ($urandom_range(0, 59) == 0);
            tick();
        end
        cfg_load = 1'b0;
        flush    = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
